// File: rtl/stopwatch_if.sv
// Control and display bundle between the code-lock state machine and the
// stopwatch counting core.
interface stopwatch_if;
  logic        clear;
  logic        enable;
  logic        freeze;
  logic [23:0] disp;
  logic        tick;
  logic        wrap;

  modport master (output clear, enable, freeze, input disp, tick, wrap);
  modport slave  (input clear, enable, freeze, output disp, tick, wrap);
endinterface

// File: rtl/stopwatch_counter.sv
// Prescaled 100 Hz timebase driving a six-digit BCD MM:SS.hh chain with a
// freezable display register and one-cycle tick/wrap pulses.
module stopwatch_counter #(
  parameter int CLK_DIV = 500000
) (
  input logic        clk,
  input logic        rst_n,
  stopwatch_if.slave bus
);
  localparam int            PW   = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]    pcnt_reg, pcnt_next;
  logic [5:0][3:0]  dig, dig_next;
  logic [5:0]       at_max;
  logic [5:0]       carry;
  logic [23:0]      disp_reg, disp_next;
  logic             tick_reg, tick_next;
  logic             wrap_reg, wrap_next;
  logic             inc;

  // Digit order in dig matches disp: [5]=min_t ... [0]=hun.
  assign inc = bus.enable & ~bus.clear & (pcnt_reg == PMAX);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      localparam logic [3:0] DMAX = (gi == 3 || gi == 5) ? 4'd5 : 4'd9;

      assign at_max[gi] = (dig[gi] == DMAX);

      // Each digit sees the increment only when every lower digit is at max.
      if (gi == 0) begin : g_lsd
        assign carry[gi] = inc;
      end else begin : g_upper
        assign carry[gi] = inc & (&at_max[gi-1:0]);
      end

      assign dig_next[gi] = bus.clear  ? 4'd0 :
                            !carry[gi] ? dig[gi] :
                            at_max[gi] ? 4'd0 : dig[gi] + 4'd1;
    end
  endgenerate

  always_comb begin
    pcnt_next = pcnt_reg;
    if (bus.clear) begin
      pcnt_next = '0;
    end else if (bus.enable) begin
      pcnt_next = (pcnt_reg == PMAX) ? '0 : pcnt_reg + PW'(1);
    end
  end

  always_comb begin
    disp_next = disp_reg;
    if (bus.clear) begin
      disp_next = '0;
    end else if (!bus.freeze) begin
      disp_next = dig;
    end
  end

  assign tick_next = inc;
  assign wrap_next = inc & (&at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg <= '0;
      dig      <= '0;
      disp_reg <= '0;
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_next;
      dig      <= dig_next;
      disp_reg <= disp_next;
      tick_reg <= tick_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bus.disp = disp_reg;
  assign bus.tick = tick_reg;
  assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed scoreboard bench for stopwatch_counter with CLK_DIV=4.
module tb_stopwatch_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  stopwatch_if bus ();

  stopwatch_counter #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          tick_seen = 0;
  int          wrap_seen = 0;
  int          t0;
  logic [31:0] sb[$];

  // Advance n cycles, sampling pulses on each falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      tick_seen += (bus.tick === 1'b1) ? 1 : 0;
      wrap_seen += (bus.wrap === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      $display("chk %-14s observed=%h expected=%h", tag, obs, e);
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_disp(input string tag, input logic [23:0] v);
    push({8'h0, v});
    chk(tag, {8'h0, bus.disp});
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic v);
    push({31'h0, v});
    chk(tag, {31'h0, obs});
  endtask

  initial begin
    bus.clear  = 1'b0;
    bus.enable = 1'b0;
    bus.freeze = 1'b0;

    // Reset state
    step(2);
    chk_disp("rst_disp", 24'h0);
    chk_bit("rst_tick", bus.tick, 1'b0);
    chk_bit("rst_wrap", bus.wrap, 1'b0);
    rst_n = 1'b1;

    // Count to 00:03.47 then reset asynchronously mid-count
    bus.clear = 1'b1; bus.enable = 1'b1;
    step(1);
    bus.clear = 1'b0;
    step(1388);
    bus.enable = 1'b0;
    step(1);
    chk_disp("pre_rst_347", 24'h000347);
    bus.enable = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_disp("async_disp", 24'h0);
    chk_bit("async_tick", bus.tick, 1'b0);
    chk_bit("async_wrap", bus.wrap, 1'b0);
    push(32'h0); chk("async_dig", {8'h0, dut.dig});
    push(32'h0); chk("async_pcnt", 32'(dut.pcnt_reg));
    @(negedge clk);
    rst_n = 1'b1;
    t0 = tick_seen;
    step(3);
    chk_bit("rel_tick_e3", bus.tick, 1'b0);
    step(1);
    chk_bit("rel_tick_e4", bus.tick, 1'b1);
    chk_disp("rel_disp_e4", 24'h0);
    step(1);
    chk_disp("rel_disp_e5", 24'h000001);
    chk_bit("rel_tick_e5", bus.tick, 1'b0);
    push(32'd1); chk("rel_tick_cnt", 32'(tick_seen - t0));

    // Carry chain
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    step(37);
    chk_disp("carry_9", 24'h000009);
    step(4);
    chk_disp("carry_10", 24'h000010);
    step(360);
    chk_disp("carry_100", 24'h000100);

    // Pause preserves the fractional period
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    step(2);
    bus.enable = 1'b0;
    t0 = tick_seen;
    step(10);
    chk_disp("pause_disp", 24'h0);
    push(32'd0); chk("pause_ticks", 32'(tick_seen - t0));
    push(32'd2); chk("pause_pcnt", 32'(dut.pcnt_reg));
    bus.enable = 1'b1;
    step(1);
    chk_bit("resume_e1", bus.tick, 1'b0);
    step(1);
    chk_bit("resume_e2", bus.tick, 1'b1);
    step(1);
    chk_disp("resume_disp", 24'h000001);

    // Freeze while counting
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    step(21);
    chk_disp("frz_start", 24'h000005);
    bus.freeze = 1'b1;
    step(80);
    chk_disp("frz_hold", 24'h000005);
    bus.freeze = 1'b0;
    bus.enable = 1'b0;
    step(1);
    chk_disp("frz_release", 24'h000025);

    // Clear beats enable and freeze
    bus.enable = 1'b1;
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    step(853);
    chk_disp("pre_clr_213", 24'h000213);
    bus.clear = 1'b1; bus.freeze = 1'b1;
    t0 = tick_seen;
    step(1);
    chk_disp("clr_disp", 24'h0);
    push(32'h0); chk("clr_dig", {8'h0, dut.dig});
    push(32'h0); chk("clr_pcnt", 32'(dut.pcnt_reg));
    step(4);
    push(32'd0); chk("clr_ticks", 32'(tick_seen - t0));
    chk_disp("clr_hold", 24'h0);
    bus.clear = 1'b0; bus.freeze = 1'b0;

    // Wrap from 59:59.99 (preloaded; counting there takes 1.44M cycles)
    bus.enable = 1'b0;
    step(1);
    force dut.dig = 24'h595999;
    force dut.pcnt_reg = 2'd3;
    step(1);
    release dut.dig;
    release dut.pcnt_reg;
    bus.enable = 1'b1;
    t0 = wrap_seen;
    step(1);
    chk_bit("wrap_tick", bus.tick, 1'b1);
    chk_bit("wrap_wrap", bus.wrap, 1'b1);
    chk_disp("wrap_old", 24'h595999);
    step(1);
    chk_disp("wrap_disp", 24'h0);
    chk_bit("wrap_tick_off", bus.tick, 1'b0);
    chk_bit("wrap_wrap_off", bus.wrap, 1'b0);
    step(4);
    push(32'd1); chk("wrap_count", 32'(wrap_seen - t0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
